fp_add_rr_sched: RTL and testbench

//  Shares one pipelined fp32 adder (fp_add, fixed-latency, no stall) among NUM_REQ requesters.

---
 rtl/fp_add_rr_sched_if.sv | 30 +++
 rtl/fp_add_rr_sched.sv | 108 ++++++++++
 tb/tb_fp_add_rr_sched.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fp_add_rr_sched_if.sv
// Bundle between the requesters, the shared fp_add instance and the round-robin scheduler.
// "slave" is the scheduler's view of the bundle; "master" is the view of whatever surrounds it.
interface fp_add_rr_sched_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic [31:0]           add_a;
  logic [31:0]           add_b;
  logic [31:0]           add_result;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_data;
  logic [ID_W+3:0]       inflight;
  logic                  busy;

  modport slave (
    input  req_valid, req_a, req_b, add_result,
    output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_data, inflight, busy
  );

  modport master (
    output req_valid, req_a, req_b, add_result,
    input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_data, inflight, busy
  );
endinterface

// File: rtl/fp_add_rr_sched.sv
// Round-robin scheduler that shares one fixed-latency pipelined fp32 adder among NUM_REQ
// requesters. The winner's operands are registered into the adder. A tag pipeline whose depth
// matches the adder latency carries the requester ID alongside, so each sum is returned to
// the requester that issued it. The block never inspects operand or result data.
module fp_add_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int ADD_LAT = 5
) (
  input  logic              clk,
  input  logic              rst,
  fp_add_rr_sched_if.slave  bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [31:0]      r_add_a;
  logic [31:0]      r_add_b;
  logic [ID_W-1:0]  r_rr_ptr;
  logic             r_issue_v;
  logic [ID_W-1:0]  r_issue_id;
  logic             r_tag_v  [ADD_LAT];
  logic [ID_W-1:0]  r_tag_id [ADD_LAT];
  logic [ID_W+3:0]  r_inflight;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_id;
  logic               w_xfer;
  logic               w_rsp_valid;

  // Round-robin search from r_rr_ptr upward, wrapping; no grant while held in reset.
  always_comb begin
    logic [ID_W:0] w_sum;
    w_sum      = '0;
    w_grant    = '0;
    w_grant_id = '0;
    w_xfer     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (ID_W+1)'(NUM_REQ);
      end
      if (!w_xfer && rst && bus.req_valid[w_sum[ID_W-1:0]]) begin
        w_xfer     = 1'b1;
        w_grant_id = w_sum[ID_W-1:0];
      end
    end
    w_grant[w_grant_id] = w_xfer;
  end

  // Issue stage: capture the winning operand pair and advance the pointer past the winner.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_add_a    <= '0;
      r_add_b    <= '0;
      r_rr_ptr   <= '0;
      r_issue_v  <= 1'b0;
      r_issue_id <= '0;
    end else begin
      r_issue_v <= w_xfer;
      if (w_xfer) begin
        r_add_a    <= bus.req_a[32*w_grant_id +: 32];
        r_add_b    <= bus.req_b[32*w_grant_id +: 32];
        r_issue_id <= w_grant_id;
        r_rr_ptr   <= (w_grant_id == ID_W'(NUM_REQ-1)) ? '0 : w_grant_id + 1'b1;
      end
    end
  end

  // Tag pipeline: shifts {valid,id} in lockstep with the adder so the tag emerges with the sum.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < ADD_LAT; s++) begin
        r_tag_v[s]  <= 1'b0;
        r_tag_id[s] <= '0;
      end
    end else begin
      r_tag_v[0]  <= r_issue_v;
      r_tag_id[0] <= r_issue_id;
      for (int s = 1; s < ADD_LAT; s++) begin
        r_tag_v[s]  <= r_tag_v[s-1];
        r_tag_id[s] <= r_tag_id[s-1];
      end
    end
  end

  assign w_rsp_valid = r_tag_v[ADD_LAT-1];

  // Outstanding-op counter: +1 per transfer, -1 per returned response, both cancel out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_xfer, w_rsp_valid})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.add_a     = r_add_a;
  assign bus.add_b     = r_add_b;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_id    = r_tag_id[ADD_LAT-1];
  assign bus.rsp_data  = bus.add_result;
  assign bus.inflight  = r_inflight;
  assign bus.busy      = (r_inflight != '0);
endmodule

// File: tb/tb_fp_add_rr_sched.sv
// Bench for fp_add_rr_sched with an adder-latency stub (result = a ^ b after ADD_LAT edges).
// Issued ops push the expected {id, data, arrival cycle} into a scoreboard; a monitor pops
// and compares on every rsp_valid.
module tb_fp_add_rr_sched;
  localparam int NUM_REQ = 4;
  localparam int ADD_LAT = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp_add_rr_sched_if #(.NUM_REQ(NUM_REQ)) bus();

  fp_add_rr_sched #(.NUM_REQ(NUM_REQ), .ADD_LAT(ADD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Adder stub: ADD_LAT register stages behind add_a/add_b
  logic [31:0] stub_pipe [ADD_LAT];
  always @(posedge clk) begin
    stub_pipe[0] <= bus.add_a ^ bus.add_b;
    for (int k = 1; k < ADD_LAT; k++) stub_pipe[k] <= stub_pipe[k-1];
  end
  assign bus.add_result = stub_pipe[ADD_LAT-1];

  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] op_a [NUM_REQ];
  logic [31:0] op_b [NUM_REQ];
  int          cnt  [NUM_REQ];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void new_ops(input int i);
    op_a[i] = 32'h1000_0000 * (i + 1) + cnt[i];
    op_b[i] = 32'h0000_0100 * (cnt[i] + 1) + i;
  endfunction

  // Monitor: every response must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_rsp: got rsp_id=%0d data=%h at cycle %0d, required no response",
                 bus.rsp_id, bus.rsp_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("rsp  id=%0d data=%h cycle=%0d", bus.rsp_id, bus.rsp_data, cyc);
        chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
        chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // One cycle of stimulus: present req_valid, check the grant, record the expected response
  task automatic cycle(input logic [3:0] v, input logic [3:0] g, input bit track);
    int   id;
    exp_t e;
    @(negedge clk);
    bus.req_valid = v;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_a[32*i +: 32] = op_a[i];
      bus.req_b[32*i +: 32] = op_b[i];
    end
    #1;
    chk("grant", 64'(bus.req_ready), 64'(g));
    if (g != 4'b0000) begin
      id = g[0] ? 0 : g[1] ? 1 : g[2] ? 2 : 3;
      $display("issue req=%0d a=%h b=%h track=%0d cycle=%0d", id, op_a[id], op_b[id], track, cyc);
      if (track) begin
        e.id   = 2'(id);
        e.data = op_a[id] ^ op_b[id];
        e.cyc  = cyc + 1 + ADD_LAT;
        sb.push_back(e);
      end
      cnt[id]++;
      new_ops(id);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    bus.req_valid = '0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(negedge clk);
    #2;
    chk("drain_inflight", 64'(bus.inflight), 64'd0);
    chk("drain_busy", 64'(bus.busy), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt[i] = 0;
      new_ops(i);
    end

    // Reset values, grant suppressed while rst=0
    rst = 1'b0;
    repeat (3) @(negedge clk);
    bus.req_valid = 4'hF;
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_add_a", 64'(bus.add_a), 64'd0);
    chk("rst_add_b", 64'(bus.add_b), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_inflight", 64'(bus.inflight), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;

    // 1) Single request, 1.0 + 2.0 operands, stub value 0x7F800000
    op_a[0] = 32'h3F80_0000;
    op_b[0] = 32'h4000_0000;
    cycle(4'b0001, 4'b0001, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b1);
    chk("t1_inflight", 64'(bus.inflight), 64'd1);
    chk("t1_busy", 64'(bus.busy), 64'd1);
    drain();

    // 2) All four continuously valid: grants rotate 0,1,2,3,...; inflight saturates at 6
    do_reset();
    for (int n = 0; n < 10; n++) cycle(4'hF, 4'(1 << (n % 4)), 1'b1);
    cycle(4'b0000, 4'b0000, 1'b1);
    chk("t2_inflight_sat", 64'(bus.inflight), 64'd6);
    drain();

    // 3) Only requester 2 valid: granted every cycle, back-to-back responses
    for (int n = 0; n < 10; n++) cycle(4'b0100, 4'b0100, 1'b1);
    drain();

    // 4) rr_ptr=3 with 1001: grant 3, then wrap to 0, then 3 again
    cycle(4'b1001, 4'b1000, 1'b1);
    cycle(4'b1001, 4'b0001, 1'b1);
    cycle(4'b1001, 4'b1000, 1'b1);
    drain();

    // 5) Three ops issued then reset: their responses must never appear
    cycle(4'b0111, 4'b0001, 1'b0);
    cycle(4'b0111, 4'b0010, 1'b0);
    cycle(4'b0111, 4'b0100, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 4'hF;
    #1;
    chk("t5_ready_in_rst", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    #1;
    chk("t5_inflight", 64'(bus.inflight), 64'd0);
    chk("t5_busy", 64'(bus.busy), 64'd0);
    chk("t5_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    repeat (8) cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'hF, 4'b0001, 1'b1);
    drain();

    // 6) A transfer on the same edge as a response leaves inflight unchanged
    cycle(4'b0001, 4'b0001, 1'b1);
    repeat (5) cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b0010, 4'b0010, 1'b1);
    chk("t6_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("t6_inflight_before", 64'(bus.inflight), 64'd1);
    cycle(4'b0000, 4'b0000, 1'b1);
    chk("t6_inflight_after", 64'(bus.inflight), 64'd1);
    chk("t6_busy", 64'(bus.busy), 64'd1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
